// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing bundle of the branch predictor: lookup request/response,
// resolved-outcome update, misprediction flag and statistics.
interface branch_predictor_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_pc;
    logic                  pred_valid;
    logic                  pred_hit;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;
    logic                  update_valid;
    logic [DATA_WIDTH-1:0] update_pc;
    logic                  update_is_jump;
    logic                  update_taken;
    logic [DATA_WIDTH-1:0] update_target;
    logic                  update_pred_taken;
    logic [DATA_WIDTH-1:0] update_pred_target;
    logic                  mispredict;
    logic [31:0]           branch_count;
    logic [31:0]           mispredict_count;

    modport master (
        output fetch_valid, fetch_pc,
        input  pred_valid, pred_hit, pred_taken, pred_target,
        output update_valid, update_pc, update_is_jump, update_taken,
        output update_target, update_pred_taken, update_pred_target,
        input  mispredict, branch_count, mispredict_count
    );

    modport slave (
        input  fetch_valid, fetch_pc,
        output pred_valid, pred_hit, pred_taken, pred_target,
        input  update_valid, update_pc, update_is_jump, update_taken,
        input  update_target, update_pred_taken, update_pred_target,
        output mispredict, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, one-cycle registered lookup,
// resolved-outcome update and branch/misprediction statistics.
module branch_predictor #(
    parameter int ENTRY_NUM  = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    branch_predictor_if.slave bp
);
    localparam int IW = $clog2(ENTRY_NUM);
    localparam int TW = DATA_WIDTH - IW - 2;

    logic                  valid_q [ENTRY_NUM];
    logic [1:0]            ctr_q   [ENTRY_NUM];
    logic [TW-1:0]         tag_q   [ENTRY_NUM];
    logic [DATA_WIDTH-1:0] tgt_q   [ENTRY_NUM];

    logic [IW-1:0]         f_idx, u_idx;
    logic [TW-1:0]         f_tag, u_tag;
    logic                  f_hit, u_hit;

    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_hit_q, pred_hit_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [DATA_WIDTH-1:0] pred_target_q, pred_target_d;

    logic                  u_wr_meta, u_wr_tgt;
    logic [1:0]            u_ctr_cur, u_ctr_d;
    logic                  mispredict;
    logic [31:0]           branch_cnt_q, branch_cnt_d;
    logic [31:0]           mispr_cnt_q, mispr_cnt_d;

    assign f_idx = bp.fetch_pc[IW+1:2];
    assign f_tag = bp.fetch_pc[DATA_WIDTH-1:IW+2];
    assign u_idx = bp.update_pc[IW+1:2];
    assign u_tag = bp.update_pc[DATA_WIDTH-1:IW+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_ctr_cur = ctr_q[u_idx];

    always_comb begin
        pred_valid_d  = bp.fetch_valid;
        pred_hit_d    = bp.fetch_valid && f_hit;
        pred_taken_d  = pred_hit_d && ctr_q[f_idx][1];
        pred_target_d = pred_hit_d ? tgt_q[f_idx] : '0;
    end

    // Only taken outcomes (re)allocate; tag and target are always written together.
    always_comb begin
        u_wr_meta = 1'b0;
        u_wr_tgt  = 1'b0;
        u_ctr_d   = u_ctr_cur;
        if (bp.update_valid) begin
            if (u_hit) begin
                u_wr_meta = 1'b1;
                if (bp.update_is_jump) begin
                    u_ctr_d  = 2'b11;
                    u_wr_tgt = 1'b1;
                end else if (bp.update_taken) begin
                    u_ctr_d  = (u_ctr_cur == 2'b11) ? 2'b11 : u_ctr_cur + 2'd1;
                    u_wr_tgt = 1'b1;
                end else begin
                    u_ctr_d  = (u_ctr_cur == 2'b00) ? 2'b00 : u_ctr_cur - 2'd1;
                end
            end else if (bp.update_taken) begin
                u_wr_meta = 1'b1;
                u_wr_tgt  = 1'b1;
                u_ctr_d   = bp.update_is_jump ? 2'b11 : 2'b10;
            end
        end
    end

    always_comb begin
        mispredict = bp.update_valid &&
                     ((bp.update_taken != bp.update_pred_taken) ||
                      (bp.update_taken && bp.update_pred_taken &&
                       (bp.update_target != bp.update_pred_target)));
        branch_cnt_d = bp.update_valid ? branch_cnt_q + 32'd1 : branch_cnt_q;
        mispr_cnt_d  = mispredict ? mispr_cnt_q + 32'd1 : mispr_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            branch_cnt_q  <= '0;
            mispr_cnt_q   <= '0;
        end else begin
            if (u_wr_meta) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= u_ctr_d;
            end
            pred_valid_q  <= pred_valid_d;
            pred_hit_q    <= pred_hit_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            branch_cnt_q  <= branch_cnt_d;
            mispr_cnt_q   <= mispr_cnt_d;
        end
    end

    // Tag/target storage is meaningless while valid=0, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && u_wr_tgt) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= bp.update_target;
        end
    end

    assign bp.pred_valid       = pred_valid_q;
    assign bp.pred_hit         = pred_hit_q;
    assign bp.pred_taken       = pred_taken_q;
    assign bp.pred_target      = pred_target_q;
    assign bp.mispredict       = mispredict;
    assign bp.branch_count     = branch_cnt_q;
    assign bp.mispredict_count = mispr_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed expectations checked with
// immediate assertions after each step.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   ebc = 0;
    int   emc = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.DATA_WIDTH(32)) bif ();

    branch_predictor #(.ENTRY_NUM(64), .DATA_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bp    (bif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bif.fetch_valid = 1'b1;
        bif.fetch_pc    = pc;
        step();
        bif.fetch_valid = 1'b0;
    endtask

    task automatic chk_pred(input string tag, input logic hit, input logic taken,
                            input logic [31:0] tgt);
        chk({tag, ".valid"},  {31'd0, bif.pred_valid}, 32'd1);
        chk({tag, ".hit"},    {31'd0, bif.pred_hit},   {31'd0, hit});
        chk({tag, ".taken"},  {31'd0, bif.pred_taken}, {31'd0, taken});
        chk({tag, ".target"}, bif.pred_target,         tgt);
    endtask

    // Drive one resolved update; mp is the hand-derived mispredict value.
    task automatic upd(input string tag, input logic [31:0] pc, input logic jump,
                       input logic taken, input logic [31:0] tgt,
                       input logic ptaken, input logic [31:0] ptgt, input logic mp);
        bif.update_valid       = 1'b1;
        bif.update_pc          = pc;
        bif.update_is_jump     = jump;
        bif.update_taken       = taken;
        bif.update_target      = tgt;
        bif.update_pred_taken  = ptaken;
        bif.update_pred_target = ptgt;
        #1;
        chk({tag, ".mispredict"}, {31'd0, bif.mispredict}, {31'd0, mp});
        step();
        bif.update_valid = 1'b0;
        ebc++;
        if (mp) emc++;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, ".branch_count"},     bif.branch_count,     ebc);
        chk({tag, ".mispredict_count"}, bif.mispredict_count, emc);
    endtask

    initial begin
        bif.fetch_valid        = 1'b0;
        bif.fetch_pc           = '0;
        bif.update_valid       = 1'b0;
        bif.update_pc          = '0;
        bif.update_is_jump     = 1'b0;
        bif.update_taken       = 1'b0;
        bif.update_target      = '0;
        bif.update_pred_taken  = 1'b0;
        bif.update_pred_target = '0;
        step();
        step();
        rst = 1'b0;

        chk("rst.pred_valid", {31'd0, bif.pred_valid}, 32'd0);
        chk_counts("rst");

        lookup(32'h0000_1000);
        chk_pred("cold", 1'b0, 1'b0, 32'h0);
        chk_counts("cold");

        upd("alloc", 32'h1000, 1'b0, 1'b1, 32'h1040, 1'b0, 32'h0, 1'b1);
        chk("idle.pred_valid", {31'd0, bif.pred_valid}, 32'd0);
        chk_counts("alloc");
        lookup(32'h1000);
        chk_pred("alloc", 1'b1, 1'b1, 32'h1040);

        // 10 -> 01 -> 00, then three more not-taken stay at 00
        upd("nt1", 32'h1000, 1'b0, 1'b0, 32'h1004, 1'b1, 32'h1040, 1'b1);
        upd("nt2", 32'h1000, 1'b0, 1'b0, 32'h1004, 1'b0, 32'h0, 1'b0);
        lookup(32'h1000);
        chk_pred("ctr00", 1'b1, 1'b0, 32'h1040);
        for (int i = 0; i < 3; i++)
            upd("nt_sat", 32'h1000, 1'b0, 1'b0, 32'h1004, 1'b0, 32'h0, 1'b0);
        upd("t1", 32'h1000, 1'b0, 1'b1, 32'h1040, 1'b1, 32'h1040, 1'b0);
        lookup(32'h1000);
        chk_pred("ctr01", 1'b1, 1'b0, 32'h1040);
        upd("t2", 32'h1000, 1'b0, 1'b1, 32'h1040, 1'b1, 32'h1040, 1'b0);
        upd("t3", 32'h1000, 1'b0, 1'b1, 32'h1040, 1'b1, 32'h1040, 1'b0);
        upd("t4", 32'h1000, 1'b0, 1'b1, 32'h1080, 1'b1, 32'h1040, 1'b1);
        upd("nt_a", 32'h1000, 1'b0, 1'b0, 32'h1004, 1'b0, 32'h0, 1'b0);
        lookup(32'h1000);
        chk_pred("ctr10", 1'b1, 1'b1, 32'h1080);
        upd("nt_b", 32'h1000, 1'b0, 1'b0, 32'h1004, 1'b0, 32'h0, 1'b0);
        lookup(32'h1000);
        chk_pred("ctr01b", 1'b1, 1'b0, 32'h1080);
        chk_counts("ctr");

        upd("alias", 32'h1100, 1'b0, 1'b1, 32'h2200, 1'b0, 32'h0, 1'b1);
        lookup(32'h1000);
        chk_pred("alias_old", 1'b0, 1'b0, 32'h0);
        lookup(32'h1100);
        chk_pred("alias_new", 1'b1, 1'b1, 32'h2200);

        upd("jump", 32'h3004, 1'b1, 1'b1, 32'h3100, 1'b1, 32'h3100, 1'b0);
        lookup(32'h3004);
        chk_pred("jump", 1'b1, 1'b1, 32'h3100);
        upd("jump_nt", 32'h3004, 1'b0, 1'b0, 32'h3008, 1'b1, 32'h3100, 1'b1);
        lookup(32'h3004);
        chk_pred("jump_nt", 1'b1, 1'b1, 32'h3100);
        upd("nt_miss", 32'h5008, 1'b0, 1'b0, 32'h500c, 1'b0, 32'h0, 1'b0);
        lookup(32'h5008);
        chk_pred("nt_miss", 1'b0, 1'b0, 32'h0);

        // Same-cycle lookup and update to one index: read-before-write
        bif.fetch_valid = 1'b1;
        bif.fetch_pc    = 32'h2000;
        upd("rbw", 32'h2000, 1'b0, 1'b1, 32'h2400, 1'b0, 32'h0, 1'b1);
        bif.fetch_valid = 1'b0;
        chk_pred("rbw_same", 1'b0, 1'b0, 32'h0);
        lookup(32'h2003);
        chk_pred("rbw_next", 1'b1, 1'b1, 32'h2400);
        chk_counts("pre_rst");

        bif.update_valid      = 1'b0;
        bif.update_taken      = 1'b1;
        bif.update_pred_taken = 1'b0;
        #1;
        chk("noupd.mispredict", {31'd0, bif.mispredict}, 32'd0);

        rst = 1'b1;
        bif.fetch_valid        = 1'b1;
        bif.fetch_pc           = 32'h2000;
        bif.update_valid       = 1'b1;
        bif.update_pc          = 32'h6000;
        bif.update_is_jump     = 1'b0;
        bif.update_taken       = 1'b1;
        bif.update_target      = 32'h6040;
        bif.update_pred_taken  = 1'b0;
        step();
        rst = 1'b0;
        bif.fetch_valid  = 1'b0;
        bif.update_valid = 1'b0;
        ebc = 0;
        emc = 0;
        chk("rst2.pred_valid", {31'd0, bif.pred_valid}, 32'd0);
        chk_counts("rst2");
        lookup(32'h2000);
        chk_pred("rst2_a", 1'b0, 1'b0, 32'h0);
        lookup(32'h3004);
        chk_pred("rst2_b", 1'b0, 1'b0, 32'h0);
        lookup(32'h6000);
        chk_pred("rst2_c", 1'b0, 1'b0, 32'h0);
        chk_counts("rst2_end");

        force dut.mispr_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.mispr_cnt_q;
        #1;
        emc = 32'hFFFF_FFFE;
        chk("preload", bif.mispredict_count, 32'hFFFF_FFFE);
        upd("wrap1", 32'h7000, 1'b0, 1'b1, 32'h7040, 1'b0, 32'h0, 1'b1);
        chk("wrap1.count", bif.mispredict_count, 32'hFFFF_FFFF);
        upd("wrap2", 32'h7000, 1'b0, 1'b0, 32'h7004, 1'b1, 32'h7040, 1'b1);
        chk("wrap2.count", bif.mispredict_count, 32'h0);
        chk("wrap2.branch_count", bif.branch_count, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the Falco core. The fetch stage sends it a PC lookup each cycle; it answers one cycle later with a taken/not-taken prediction and a predicted target. The execute stage sends back each resolved control-transfer outcome, and the predictor updates its table from that. It combines a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and also keeps branch and misprediction statistics counters.

## Interface
- ENTRY_NUM, 64: number of table entries; power of two, 4–1024.
- DATA_WIDTH, 32: address width, same as the core's XLEN.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_valid  in  1  lookup request this cycle.
- fetch_pc  in  DATA_WIDTH  PC to look up.
- pred_valid  out  1  registered; high one cycle after each accepted lookup.
- pred_hit  out  1  registered; BTB tag matched a valid entry.
- pred_taken  out  1  registered; high when pred_hit is high and counter[1] is 1.
- pred_target  out  DATA_WIDTH  registered; BTB target when pred_hit is high, else 0.
- update_valid  in  1  a resolved branch or jump is presented.
- update_pc  in  DATA_WIDTH  PC of the resolved instruction.
- update_is_jump  in  1  1 = JAL/JALR, 0 = conditional branch.
- update_taken  in  1  resolved outcome; for branches this is the compare result.
- update_target  in  DATA_WIDTH  resolved target address.
- update_pred_taken  in  1  prediction that was used for this instruction.
- update_pred_target  in  DATA_WIDTH  predicted target that was used.
- mispredict  out  1  combinational; update_valid && misprediction condition.
- branch_count  out  32  count of resolved updates.
- mispredict_count  out  32  count of mispredictions.

## Operation
- IW = log2(ENTRY_NUM).
- Index = pc[IW+1:2].
- Tag = pc[DATA_WIDTH-1:IW+2].
- pc[1:0] is ignored.
- Each entry holds valid (1 bit), tag, target (DATA_WIDTH bits) and ctr (2 bits).
- Lookup: on a clock edge with fetch_valid=1, the entry at index(fetch_pc) is read and all four pred_* outputs are registered.
- When fetch_valid=0 at an edge, pred_valid goes to 0 and the other pred_* outputs go to 0.
- Update when update_valid=1 and the entry at index(update_pc) is a hit (valid and tag match):
  - Jump: ctr := 11 and target := update_target.
  - Branch, taken: ctr := sat_inc(ctr) and target := update_target.
  - Branch, not taken: ctr := sat_dec(ctr); target is unchanged.
- Update when update_valid=1 and the entry is a miss:
  - update_taken=1: allocate or replace the entry. Set valid=1, tag := tag(update_pc), target := update_target. Set ctr := 11 for a jump, 10 for a branch.
  - update_taken=0: no table change (not-taken instructions never allocate).
- Counter saturation: sat_inc(11)=11 and sat_dec(00)=00.
- Misprediction condition: (update_taken != update_pred_taken), or (update_taken && update_pred_taken && update_target != update_pred_target).
- Statistics:
  - branch_count increments once per update_valid cycle.
  - mispredict_count increments once per cycle in which mispredict=1.
  - Both wrap from 0xFFFFFFFF to 0.

## Timing
- Reset (synchronous, any time, including mid-operation):
  - All entry valid bits, all ctr fields, pred_* outputs, branch_count and mispredict_count go to 0.
  - Tag and target storage need not be cleared.
  - Any lookup or update presented in the reset cycle is discarded.
- Lookup latency: exactly 1 cycle. There is no stall or backpressure; a new lookup is accepted every cycle.
- Updates are written at the edge where update_valid=1. A lookup registered at a later edge sees the new contents.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents (read-before-write, no bypass). The update still takes effect.
- Lookup and update to different indices in the same cycle: the two are independent.
- mispredict is purely combinational from the update_* inputs and is 0 whenever update_valid=0.
- The statistics counters change on the edge after the qualifying update.

## Test plan
- Reset, then lookup 0x0000_1000 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0; both counts are 0.
- Taken branch update at 0x1000 with target 0x1040 and pred_taken=0, then lookup 0x1000 -> pred_hit=1, pred_taken=1 (ctr=10), target=0x1040; mispredict pulses 1; both counts are 1.
- Two not-taken updates at 0x1000 -> ctr 10→01→00, and lookup gives pred_taken=0. Three further not-taken updates keep ctr=00. Four taken updates saturate ctr at 11.
- Aliasing: with ENTRY_NUM=64, a taken update at 0x1000 followed by a taken update at 0x1100 (same index, different tag) replaces the entry. Lookup 0x1000 then misses; lookup 0x1100 hits.
- Same-cycle lookup and update at 0x2000 on an empty table -> pred_hit=0 that cycle. A lookup in the next cycle returns pred_hit=1.
- Reset asserted for one cycle after several allocations -> every later lookup misses and the counts read 0. mispredict_count wraps correctly after being preloaded near 0xFFFFFFFF through a forced sequence (bench force).
